// File: rtl/fp_vec_mul_sequencer.sv
// ============================================================================
// Module   : fp_vec_mul_sequencer
// Brief    : Element-wise vector multiply sequencer around a combinational
//            FP multiplier (A/B operand banks in, result bank R out).
//            Optional infinite-result counter: define FPVEC_OVF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_vec_mul_sequencer #(
    parameter int VLEN = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic          i_wr_sel,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data,
    input  logic [AW:0]   i_vlen,
    input  logic          i_mode_half,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data,
    output logic [31:0]   o_mul_a,
    output logic [31:0]   o_mul_b,
    output logic          o_mul_sel,
    input  logic [31:0]   i_mul_product,
    output logic [AW:0]   o_ovf_count
);

    localparam logic [AW:0] C_VLEN = (AW+1)'(VLEN);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [31:0]   r_bank_a [VLEN];
    logic [31:0]   r_bank_b [VLEN];
    logic [31:0]   r_bank_r [VLEN];
    logic [AW:0]   r_n;
    logic [AW:0]   r_idx;
    logic [AW-1:0] r_iss_idx;
    logic          r_iss_v;
    logic          r_busy;
    logic          r_done;
    logic          r_mul_sel;
    logic [31:0]   r_mul_a;
    logic [31:0]   r_mul_b;
    logic [31:0]   r_rd_data;

    logic [AW:0]   w_n;
    logic          w_accept;
    logic          w_wr_ok;

    assign w_n      = (i_vlen > C_VLEN) ? C_VLEN : i_vlen;
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_wr_ok  = (r_state == S_IDLE) && i_wr_en;

    // Operand banks are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !i_wr_sel) r_bank_a[i_wr_addr] <= i_wr_data;
        if (w_wr_ok &&  i_wr_sel) r_bank_b[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_idx     <= '0;
            r_iss_idx <= '0;
            r_iss_v   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mul_sel <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_rd_data <= '0;
            for (int i = 0; i < VLEN; i++) r_bank_r[i] <= '0;
        end else begin
            // Read sees the pre-capture value when addresses collide.
            r_rd_data <= r_bank_r[i_rd_addr];
            if (r_iss_v) r_bank_r[r_iss_idx] <= i_mul_product;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n       <= w_n;
                        r_mul_sel <= i_mode_half;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        if (w_n == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_mul_a   <= r_bank_a[r_idx[AW-1:0]];
                    r_mul_b   <= r_bank_b[r_idx[AW-1:0]];
                    r_iss_idx <= r_idx[AW-1:0];
                    r_iss_v   <= 1'b1;
                    r_idx     <= r_idx + C_ONE;
                    if (r_idx == r_n - C_ONE) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_iss_v <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FPVEC_OVF_CNT_EN
    logic [AW:0] r_ovf_cnt;
    logic        w_exp_ones;

    assign w_exp_ones = r_mul_sel ? (&i_mul_product[14:10]) : (&i_mul_product[30:23]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_accept) begin
            r_ovf_cnt <= '0;
        end else if (r_iss_v && w_exp_ones && (r_ovf_cnt != C_VLEN)) begin
            r_ovf_cnt <= r_ovf_cnt + C_ONE;
        end
    end

    assign o_ovf_count = r_ovf_cnt;
`else
    assign o_ovf_count = '0;
`endif

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rd_data = r_rd_data;
    assign o_mul_a   = r_mul_a;
    assign o_mul_b   = r_mul_b;
    assign o_mul_sel = r_mul_sel;

endmodule

`default_nettype wire

// File: tb/tb_fp_vec_mul_sequencer.sv
// ============================================================================
// Module   : tb_fp_vec_mul_sequencer
// Brief    : Directed self-checking bench for fp_vec_mul_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_vec_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  vlen;
    logic        mode_half;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sel;
    logic [31:0] mul_product;
    logic [3:0]  ovf_count;

    int n_chk  = 0;
    int n_pass = 0;

    fp_vec_mul_sequencer #(.VLEN(8), .AW(3)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_sel     (wr_sel),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_vlen       (vlen),
        .i_mode_half  (mode_half),
        .i_start      (start),
        .o_busy       (busy),
        .o_done       (done),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .o_mul_sel    (mul_sel),
        .i_mul_product(mul_product),
        .o_ovf_count  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: hand-computed products, XOR for unlisted pairs.
    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (!s && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (!s && a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
        if (!s && a == 32'h7F000000 && b == 32'h7F000000) return 32'h7F800000;
        if ( s && a == 32'h00004000 && b == 32'h00004200) return 32'h00004600;
        return a ^ b;
    endfunction

    assign mul_product = f_mul(mul_a, mul_b, mul_sel);

    function automatic logic [31:0] f_opa(input int i);
        return 32'h01000000 * (i + 1);
    endfunction

    function automatic logic [31:0] f_opb(input int i);
        return 32'h00000010 * (i + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic wr(input logic sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [31:0] data);
        @(negedge clk);
        rd_addr = 3'(addr);
        @(negedge clk);
        data = rd_data;
    endtask

    // Called at a negedge inside cycle c0; returns the cycle in which done is seen.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run(input int n, input logic half, output int cyc);
        @(negedge clk);
        vlen      = 4'(n);
        mode_half = half;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done(1, cyc);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, i, f_opa(i));
            wr(1'b1, i, f_opb(i));
        end
    endtask

    logic [31:0] v;
    int          cyc;
    bit          seen_done;
    logic [31:0] exp_ovf;

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        vlen = '0; mode_half = 1'b0; start = 1'b0; rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf",  32'(ovf_count), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk($sformatf("rst_R%0d", i), v, 32'd0);
        end

        // Single precision, n=2
        wr(1'b0, 0, 32'h40000000);
        wr(1'b0, 1, 32'h3FC00000);
        wr(1'b1, 0, 32'h40400000);
        wr(1'b1, 1, 32'h3FC00000);
        run(2, 1'b0, cyc);
        chk("sp_done_cycle", 32'(cyc), 32'd4);
        chk("sp_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sp_done_pulse", 32'(done), 32'd0);
        chk("sp_busy_after", 32'(busy), 32'd0);
        rd(0, v); chk("sp_R0", v, 32'h40C00000);
        rd(1, v); chk("sp_R1", v, 32'h40100000);
        rd(2, v); chk("sp_R2_untouched", v, 32'd0);

        // Half precision, n=1
        wr(1'b0, 0, 32'h00004000);
        wr(1'b1, 0, 32'h00004200);
        run(1, 1'b1, cyc);
        chk("hp_done_cycle", 32'(cyc), 32'd3);
        chk("hp_mul_sel", 32'(mul_sel), 32'd1);
        rd(0, v); chk("hp_R0", v, 32'h00004600);
        rd(1, v); chk("hp_R1_kept", v, 32'h40100000);

        // Infinite product
        wr(1'b0, 0, 32'h7F000000);
        wr(1'b1, 0, 32'h7F000000);
        run(1, 1'b0, cyc);
`ifdef FPVEC_OVF_CNT_EN
        exp_ovf = 32'd1;
`else
        exp_ovf = 32'd0;
`endif
        chk("ovf_mul_sel", 32'(mul_sel), 32'd0);
        rd(0, v); chk("ovf_R0", v, 32'h7F800000);
        chk("ovf_count", 32'(ovf_count), exp_ovf);

        // Protocol: write and start while busy are dropped
        load_pattern();
        @(negedge clk);
        vlen = 4'd4; mode_half = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 32'h12345678;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b1; vlen = 4'd8;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, cyc);
        chk("prot_done_cycle", 32'(cyc), 32'd6);
        chk("prot_ovf_cleared", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(i, v);
            chk($sformatf("prot_R%0d", i), v, f_opa(i) ^ f_opb(i));
        end
        chk("prot_idle_busy", 32'(busy), 32'd0);

        // Zero-length run
        run(0, 1'b0, cyc);
        chk("n0_done_cycle", 32'(cyc), 32'd1);
        chk("n0_busy", 32'(busy), 32'd1);
        rd(0, v); chk("n0_R0_kept", v, f_opa(0) ^ f_opb(0));

        // Abort mid-run with reset
        @(negedge clk);
        vlen = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c < 4; c++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ovf", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk($sformatf("abort_R%0d", i), v, 32'd0);
        end

        // Fresh run after abort, vlen above VLEN clamps to 8
        run(9, 1'b0, cyc);
        chk("clamp_done_cycle", 32'(cyc), 32'd10);
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk($sformatf("clamp_R%0d", i), v, f_opa(i) ^ f_opb(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
